// File: rtl/reg_bank_arbiter_if.sv
// Requester and register-bank signals shared by reg_bank_arbiter.
// Arbiter side uses the slave modport; requesters and bank use master.
interface reg_bank_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              req_a;
    logic              req_b;
    logic              we_a;
    logic              we_b;
    logic [ADDR_W-1:0] rx_a;
    logic [ADDR_W-1:0] rx_b;
    logic [ADDR_W-1:0] ry_a;
    logic [ADDR_W-1:0] ry_b;
    logic [DATA_W-1:0] wd_a;
    logic [DATA_W-1:0] wd_b;

    logic              gnt_a;
    logic              gnt_b;
    logic              done_a;
    logic              done_b;
    logic [DATA_W-1:0] rdx_a;
    logic [DATA_W-1:0] rdy_a;
    logic [DATA_W-1:0] rdx_b;
    logic [DATA_W-1:0] rdy_b;
    logic              busy;

    logic [2*ADDR_W-1:0] Sel_reg;
    logic                W;
    logic [DATA_W-1:0]   DW;
    logic [DATA_W-1:0]   Rx;
    logic [DATA_W-1:0]   Ry;

    modport master (
        output req_a, req_b, we_a, we_b,
        output rx_a, rx_b, ry_a, ry_b,
        output wd_a, wd_b,
        input  gnt_a, gnt_b, done_a, done_b,
        input  rdx_a, rdy_a, rdx_b, rdy_b,
        input  busy,
        input  Sel_reg, W, DW,
        output Rx, Ry
    );

    modport slave (
        input  req_a, req_b, we_a, we_b,
        input  rx_a, rx_b, ry_a, ry_b,
        input  wd_a, wd_b,
        output gnt_a, gnt_b, done_a, done_b,
        output rdx_a, rdy_a, rdx_b, rdy_b,
        output busy,
        output Sel_reg, W, DW,
        input  Rx, Ry
    );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Two-requester register-bank arbiter: IDLE -> ACCESS -> DONE per transaction.
// Define ARB_RR_EN for round-robin ties; otherwise requester A has fixed priority.
module reg_bank_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input logic               clk,
    input logic               rst,
    reg_bank_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic              grant_a;
    logic              grant_b;
    logic              pick_a;
    logic              owner_b_q;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_x;
    logic [ADDR_W-1:0] sel_y;
    logic [DATA_W-1:0] sel_wd;

`ifdef ARB_RR_EN
    // Pointer remembers the last winner; reset as "B last" so A takes the first tie.
    logic last_b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_b_q <= 1'b1;
        end else if (grant_a || grant_b) begin
            last_b_q <= grant_b;
        end
    end

    assign pick_a = bus.req_a & (~bus.req_b | last_b_q);
`else
    assign pick_a = bus.req_a;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_a = 1'b0;
        grant_b = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_a || bus.req_b) begin
                    state_d = ACCESS;
                    grant_a = pick_a;
                    grant_b = ~pick_a;
                end
            end
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_we = grant_b ? bus.we_b : bus.we_a;
        sel_x  = grant_b ? bus.rx_b : bus.rx_a;
        sel_y  = grant_b ? bus.ry_b : bus.ry_a;
        sel_wd = grant_b ? bus.wd_b : bus.wd_a;
    end

    assign bus.busy = (state_q != IDLE);

    // Bank-facing outputs are only non-zero during ACCESS; async reset kills W at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.gnt_a   <= 1'b0;
            bus.gnt_b   <= 1'b0;
            bus.done_a  <= 1'b0;
            bus.done_b  <= 1'b0;
            bus.W       <= 1'b0;
            bus.Sel_reg <= '0;
            bus.DW      <= '0;
            owner_b_q   <= 1'b0;
        end else begin
            bus.gnt_a  <= grant_a;
            bus.gnt_b  <= grant_b;
            bus.done_a <= (state_q == ACCESS) & ~owner_b_q;
            bus.done_b <= (state_q == ACCESS) & owner_b_q;
            if (grant_a || grant_b) begin
                owner_b_q <= grant_b;
                bus.W     <= sel_we;
                if (sel_we) begin
                    bus.Sel_reg <= {{ADDR_W{1'b0}}, sel_y};
                    bus.DW      <= sel_wd;
                end else begin
                    bus.Sel_reg <= {sel_x, sel_y};
                    bus.DW      <= '0;
                end
            end else begin
                bus.W       <= 1'b0;
                bus.Sel_reg <= '0;
                bus.DW      <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rdx_a <= '0;
            bus.rdy_a <= '0;
            bus.rdx_b <= '0;
            bus.rdy_b <= '0;
        end else if (state_q == ACCESS && !bus.W) begin
            if (owner_b_q) begin
                bus.rdx_b <= bus.Rx;
                bus.rdy_b <= bus.Ry;
            end else begin
                bus.rdx_a <= bus.Rx;
                bus.rdy_a <= bus.Ry;
            end
        end
    end
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter with a behavioural 8x8 register bank.
// Build with +define+ARB_RR_EN to check the round-robin variant.
module tb_reg_bank_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    reg_bank_arbiter_if bus ();

    reg_bank_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] bank [8];

    always @(posedge clk) begin
        if (bus.W) bank[bus.Sel_reg[2:0]] <= bus.DW;
    end

    assign bus.Rx = bank[bus.Sel_reg[5:3]];
    assign bus.Ry = bank[bus.Sel_reg[2:0]];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic xact(input bit b, input bit we, input logic [2:0] rx,
                        input logic [2:0] ry, input logic [7:0] wd);
        logic [5:0] sel;
        sel = we ? {3'b000, ry} : {rx, ry};
        if (b) begin
            bus.req_b = 1'b1; bus.we_b = we;
            bus.rx_b = rx; bus.ry_b = ry; bus.wd_b = wd;
        end else begin
            bus.req_a = 1'b1; bus.we_a = we;
            bus.rx_a = rx; bus.ry_a = ry; bus.wd_a = wd;
        end
        step();
        chk("gnt_win", b ? bus.gnt_b : bus.gnt_a, 1);
        chk("gnt_lose", b ? bus.gnt_a : bus.gnt_b, 0);
        chk("sel_access", bus.Sel_reg, sel);
        chk("w_access", bus.W, we);
        chk("dw_access", bus.DW, we ? wd : 8'h00);
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        step();
        chk("done_win", b ? bus.done_b : bus.done_a, 1);
        chk("w_done", bus.W, 0);
        step();
        chk("busy_idle", bus.busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.req_a = 0; bus.req_b = 0; bus.we_a = 0; bus.we_b = 0;
        bus.rx_a = 0; bus.rx_b = 0; bus.ry_a = 0; bus.ry_b = 0;
        bus.wd_a = 0; bus.wd_b = 0;
        repeat (2) step();
        chk("rst_gnt", {bus.gnt_a, bus.gnt_b}, 0);
        chk("rst_done", {bus.done_a, bus.done_b}, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_w", bus.W, 0);
        chk("rst_sel", bus.Sel_reg, 0);
        chk("rst_dw", bus.DW, 0);
        chk("rst_rd", {bus.rdx_a, bus.rdy_a, bus.rdx_b, bus.rdy_b}, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) xact(0, 1, 3'd0, 3'(i), 8'(8'h0A + i));
        xact(1, 0, 3'd0, 3'd7, 8'h00);
        chk("fill_rdx_b0", bus.rdx_b, 8'h0A);
        chk("fill_rdy_b0", bus.rdy_b, 8'h11);
        xact(1, 0, 3'd1, 3'd6, 8'h00);
        chk("fill_rdx_b1", bus.rdx_b, 8'h0B);
        chk("fill_rdy_b1", bus.rdy_b, 8'h10);
        chk("fill_rd_a_kept", {bus.rdx_a, bus.rdy_a}, 0);

        xact(0, 1, 3'd0, 3'd3, 8'h5A);
        xact(0, 0, 3'd3, 3'd0, 8'h00);
        chk("wr_rd_rdx_a", bus.rdx_a, 8'h5A);
        chk("wr_rd_rdy_a", bus.rdy_a, 8'h0A);
        chk("wr_rd_b_kept", {bus.rdx_b, bus.rdy_b}, 16'h0B10);

        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        bus.we_a = 0; bus.we_b = 0;
        bus.rx_a = 0; bus.ry_a = 1; bus.rx_b = 2; bus.ry_b = 3;
        bus.req_a = 1; bus.req_b = 1;
        for (int k = 0; k < 4; k++) begin
            bit exp_a;
`ifdef ARB_RR_EN
            exp_a = (k % 2) == 0;
`else
            exp_a = 1'b1;
`endif
            step();
            chk($sformatf("tie_gnt_a%0d", k), bus.gnt_a, exp_a);
            chk($sformatf("tie_gnt_b%0d", k), bus.gnt_b, !exp_a);
            if (k == 3) begin
                bus.req_a = 0;
                bus.req_b = 0;
            end
            step();
            chk($sformatf("tie_done%0d", k), {bus.done_a, bus.done_b},
                exp_a ? 2'b10 : 2'b01);
            step();
        end

        bus.req_a = 1; bus.we_a = 1; bus.ry_a = 3'd2; bus.wd_a = 8'hFF;
        step();
        chk("abort_w_pre", bus.W, 1);
        bus.req_a = 0;
        #2 rst = 1'b1;
        #1;
        chk("abort_w_async", bus.W, 0);
        chk("abort_sel", bus.Sel_reg, 0);
        chk("abort_busy", bus.busy, 0);
        step();
        chk("abort_no_done", bus.done_a, 0);
        rst = 1'b0;
        step();
        chk("abort_no_done2", bus.done_a, 0);
        xact(0, 0, 3'd2, 3'd2, 8'h00);
        chk("abort_reg2_rdx", bus.rdx_a, 8'h0C);
        chk("abort_reg2_rdy", bus.rdy_a, 8'h0C);

        begin
            int ng = 0;
            int nd = 0;
            bus.req_a = 1; bus.we_a = 1; bus.ry_a = 3'd5; bus.wd_a = 8'h33;
            for (int c = 0; c < 9; c++) begin
                int ph;
                ph = c % 3;
                step();
                ng += int'(bus.gnt_a);
                nd += int'(bus.done_a);
                chk($sformatf("b2b_busy%0d", c), bus.busy, ph != 2);
                chk($sformatf("b2b_w%0d", c), bus.W, ph == 0);
                chk($sformatf("b2b_sel%0d", c), bus.Sel_reg,
                    ph == 0 ? 6'd5 : 6'd0);
                chk($sformatf("b2b_gntb%0d", c), bus.gnt_b, 0);
            end
            bus.req_a = 0;
            chk("b2b_gnt_count", ng, 3);
            chk("b2b_done_count", nd, 3);
            step();
            chk("b2b_idle", bus.busy, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
